// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM port arbiter shared by the instruction fetch path and the load/store unit.
// Each request is split into per-byte RAM cycles; results return as one-cycle done pulses.
module mem_port_arbiter #(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000)
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_pipline,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t              state;
    logic                f_v;
    logic [ADDR_W-1:0]   f_addr;
    logic                d_v;
    logic                dq_we;
    logic [1:0]          dq_size;
    logic [ADDR_W-1:0]   dq_addr;
    logic [DATA_W-1:0]   dq_wdata;

    logic [ADDR_W-1:0]   base;
    logic [1:0]          last;
    logic [1:0]          cur;
    logic                issuing;
    logic                cap_v;
    logic [1:0]          cap_idx;
    logic                serve_d;
    logic [DATA_W-1:0]   rbuf;
    logic [DATA_W-1:0]   wbuf;
    logic                wr_q;

    logic                f_take;
    logic                d_take;
    logic                f_eff;
    logic                d_eff;
    logic [ADDR_W-1:0]   f_sel_addr;
    logic [ADDR_W-1:0]   d_sel_addr;
    logic                d_sel_we;
    logic [1:0]          d_sel_size;
    logic [DATA_W-1:0]   d_sel_wdata;
    logic                io_stall;
    logic [DATA_W-1:0]   rbuf_cap;

    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [BYTE_W-1:0] byte_at(input logic [DATA_W-1:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: BYTE_W];
    endfunction

    // Slot acceptance and the effective (slot or same-edge) request seen by arbitration.
    always_comb begin
        f_take      = if_req & ~f_v & ~flush_pipline;
        d_take      = d_req & ~d_v & ~flush_pipline;
        f_eff       = (f_v & ~flush_pipline) | f_take;
        d_eff       = (d_v & ~(flush_pipline & ~dq_we)) | d_take;
        f_sel_addr  = f_v ? f_addr   : if_addr;
        d_sel_addr  = d_v ? dq_addr  : d_addr;
        d_sel_we    = d_v ? dq_we    : d_we;
        d_sel_size  = d_v ? dq_size  : d_size;
        d_sel_wdata = d_v ? dq_wdata : d_wdata;
        io_stall    = io_buffer_full & ((mem_a == IO_BASE) | (mem_a == IO_BASE + ADDR_W'(4)));
        rbuf_cap    = rbuf;
        rbuf_cap[{cap_idx, 3'b000} +: BYTE_W] = mem_din;
    end

    // Write strobe is qualified late so a pause or a full IO buffer never commits a byte.
    assign mem_wr = wr_q & rdy_in & ~io_stall;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            f_v      <= 1'b0;
            f_addr   <= '0;
            d_v      <= 1'b0;
            dq_we    <= 1'b0;
            dq_size  <= '0;
            dq_addr  <= '0;
            dq_wdata <= '0;
            base     <= '0;
            last     <= '0;
            cur      <= '0;
            issuing  <= 1'b0;
            cap_v    <= 1'b0;
            cap_idx  <= '0;
            serve_d  <= 1'b0;
            rbuf     <= '0;
            wbuf     <= '0;
            wr_q     <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
            if_done  <= 1'b0;
            if_data  <= '0;
            d_done   <= 1'b0;
            d_rdata  <= '0;
        end else begin
            if_done <= 1'b0;
            d_done  <= 1'b0;
            if (rdy_in) begin
                if (f_take) begin
                    f_v    <= 1'b1;
                    f_addr <= if_addr;
                end
                if (d_take) begin
                    d_v      <= 1'b1;
                    dq_we    <= d_we;
                    dq_size  <= d_size;
                    dq_addr  <= d_addr;
                    dq_wdata <= d_wdata;
                end
                if (flush_pipline) begin
                    f_v <= 1'b0;
                    if (d_v && !dq_we) d_v <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (d_eff || f_eff) begin
                            issuing <= 1'b1;
                            cur     <= 2'd0;
                            cap_v   <= 1'b0;
                            rbuf    <= '0;
                        end
                        // Data side wins; the later slot clear overrides a same-edge latch.
                        if (d_eff) begin
                            d_v     <= 1'b0;
                            serve_d <= 1'b1;
                            base    <= d_sel_addr;
                            mem_a   <= d_sel_addr;
                            last    <= last_idx(d_sel_size);
                            if (d_sel_we) begin
                                wr_q     <= 1'b1;
                                wbuf     <= d_sel_wdata;
                                mem_dout <= d_sel_wdata[BYTE_W-1:0];
                                state    <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end else if (f_eff) begin
                            f_v     <= 1'b0;
                            serve_d <= 1'b0;
                            base    <= f_sel_addr;
                            mem_a   <= f_sel_addr;
                            last    <= 2'd3;
                            state   <= READ;
                        end
                    end

                    READ: begin
                        if (flush_pipline) begin
                            state   <= IDLE;
                            cap_v   <= 1'b0;
                            issuing <= 1'b0;
                        end else begin
                            if (cap_v) begin
                                rbuf <= rbuf_cap;
                                if (cap_idx == last) begin
                                    state <= IDLE;
                                    if (serve_d) begin
                                        d_done  <= 1'b1;
                                        d_rdata <= rbuf_cap;
                                    end else begin
                                        if_done <= 1'b1;
                                        if_data <= rbuf_cap;
                                    end
                                end
                            end
                            cap_v   <= issuing;
                            cap_idx <= cur;
                            if (issuing) begin
                                if (cur == last) begin
                                    issuing <= 1'b0;
                                end else begin
                                    cur   <= cur + 2'd1;
                                    mem_a <= base + ADDR_W'(cur + 2'd1);
                                end
                            end
                        end
                    end

                    WRITE: begin
                        if (!io_stall) begin
                            if (cur == last) begin
                                wr_q   <= 1'b0;
                                d_done <= 1'b1;
                                state  <= IDLE;
                            end else begin
                                cur      <= cur + 2'd1;
                                mem_a    <= base + ADDR_W'(cur + 2'd1);
                                mem_dout <= byte_at(wbuf, cur + 2'd1);
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end else if (state == READ && cap_v) begin
                // The byte on mem_din is lost while paused: rewind and re-issue its address.
                cap_v   <= 1'b0;
                cur     <= cap_idx;
                mem_a   <= base + ADDR_W'(cap_idx);
                issuing <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for collision, flush, IO throttling, pause and async reset.
module tb_mem_port_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_pipline = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic [31:0] if_data;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_done;
    logic [31:0] d_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    logic [7:0] ram [0:4095];

    always #5 clk_in = ~clk_in;

    mem_port_arbiter dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .flush_pipline(flush_pipline), .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_done(d_done), .d_rdata(d_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    // Byte RAM: read data appears one cycle after its address.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr === 1'b1) begin
            ram[mem_a[11:0]] = mem_dout;
            wr_count = wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_a"}, mem_a, 32'h0);
        chk({tag, " mem_dout"}, 32'(mem_dout), 32'h0);
        chk({tag, " mem_wr"}, 32'(mem_wr), 32'h0);
        chk({tag, " if_done"}, 32'(if_done), 32'h0);
        chk({tag, " d_done"}, 32'(d_done), 32'h0);
        chk({tag, " if_data"}, if_data, 32'h0);
        chk({tag, " d_rdata"}, d_rdata, 32'h0);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          n;
        int          done_cyc;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        v;
        logic [31:0] sh;
        logic [31:0] got;
        int          w0;
        int          nif;
        int          nd;

        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h100, 32'h0,        32'h0000_0513, 4, 5};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 32'h300, 32'h0,        32'h0000_007F, 1, 2};
        vecs[2] = '{1'b1, 1'b0, 2'd1, 32'h122, 32'h0,        32'h0000_4433, 2, 3};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 32'h120, 32'h0,        32'h4433_2211, 4, 5};
        vecs[4] = '{1'b1, 1'b1, 2'd1, 32'h200, 32'hABCD1234, 32'h0,         2, 2};
        vecs[5] = '{1'b1, 1'b1, 2'd2, 32'h210, 32'hDEADBEEF, 32'h0,         4, 4};
        vecs[6] = '{1'b1, 1'b1, 2'd0, 32'h220, 32'h0000_00A5, 32'h0,        1, 1};
        vecs[7] = '{1'b1, 1'b0, 2'd2, 32'h121, 32'h0,        32'h5544_3322, 4, 5};
        vecs[8] = '{1'b1, 1'b0, 2'd2, 32'h210, 32'h0,        32'hDEAD_BEEF, 4, 5};

        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h120] = 8'h11; ram[12'h121] = 8'h22; ram[12'h122] = 8'h33; ram[12'h123] = 8'h44;
        ram[12'h124] = 8'h55; ram[12'h300] = 8'h7F;

        #1 rst_n_in = 1'b0;
        @(negedge clk_in);
        chk_reset_outputs("reset");
        tick;
        rst_n_in = 1'b1;
        tick;
        tick;

        // Single transactions from the table.
        for (int i = 0; i < NV; i++) begin
            v  = vecs[i];
            w0 = wr_count;
            if (v.is_d) begin
                d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
            end else begin
                if_req = 1'b1; if_addr = v.addr;
            end
            tick;
            if_req = 1'b0;
            d_req  = 1'b0;
            for (int k = 0; k <= v.done_cyc + 1; k++) begin
                @(negedge clk_in);
                chk($sformatf("v%0d c%0d mem_a", i, k), mem_a,
                    v.addr + 32'((k < v.n) ? k : v.n - 1));
                chk($sformatf("v%0d c%0d mem_wr", i, k), 32'(mem_wr), 32'(v.we && (k < v.n)));
                if (v.we && k < v.n) begin
                    sh = v.wdata >> (8 * k);
                    chk($sformatf("v%0d c%0d mem_dout", i, k), 32'(mem_dout), 32'(sh[7:0]));
                end
                chk($sformatf("v%0d c%0d d_done", i, k), 32'(d_done), 32'(v.is_d && k == v.done_cyc));
                chk($sformatf("v%0d c%0d if_done", i, k), 32'(if_done), 32'(!v.is_d && k == v.done_cyc));
                if (k == v.done_cyc && !v.we) begin
                    chk($sformatf("v%0d data", i), v.is_d ? d_rdata : if_data, v.exp_data);
                end
                tick;
            end
            chk($sformatf("v%0d write count", i), 32'(wr_count - w0), 32'(v.we ? v.n : 0));
        end

        // Collision: load served first, fetch issues right after the load's done cycle.
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_addr = 32'h300;
        tick;
        if_req = 1'b0; d_req = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk_in);
            if (k == 0) chk("coll mem_a c0", mem_a, 32'h300);
            if (k == 3) chk("coll mem_a c3", mem_a, 32'h100);
            if (k == 6) chk("coll mem_a c6", mem_a, 32'h103);
            chk($sformatf("coll c%0d d_done", k), 32'(d_done), 32'(k == 2));
            chk($sformatf("coll c%0d if_done", k), 32'(if_done), 32'(k == 8));
            if (k == 2) chk("coll d_rdata", d_rdata, 32'h0000_007F);
            if (k == 8) chk("coll if_data", if_data, 32'h0000_0513);
            tick;
        end

        // Flush during a fetch with a pending load: neither completes.
        if_req = 1'b1; if_addr = 32'h100;
        tick;
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_addr = 32'h300;
        tick;
        d_req = 1'b0;
        tick;
        flush_pipline = 1'b1;
        tick;
        flush_pipline = 1'b0;
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            nd += int'(if_done) + int'(d_done);
            tick;
        end
        chk("flush load dones", 32'(nd), 32'h0);

        // Flush during a fetch with a pending store: the store still completes.
        if_req = 1'b1; if_addr = 32'h100;
        tick;
        if_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h230; d_wdata = 32'h0000_005A;
        tick;
        d_req = 1'b0;
        tick;
        flush_pipline = 1'b1;
        w0 = wr_count;
        tick;
        flush_pipline = 1'b0;
        nif = 0; nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            nif += int'(if_done);
            nd  += int'(d_done);
            tick;
        end
        chk("flush store if_done", 32'(nif), 32'h0);
        chk("flush store d_done", 32'(nd), 32'h1);
        chk("flush store writes", 32'(wr_count - w0), 32'h1);
        chk("flush store ram", 32'(ram[12'h230]), 32'h5A);

        // IO throttle: three blocked cycles, then exactly one write.
        io_buffer_full = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h0003_0000; d_wdata = 32'h0000_0077;
        w0 = wr_count;
        tick;
        d_req = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk_in);
            chk($sformatf("io c%0d mem_wr", k), 32'(mem_wr), 32'(k == 3));
            chk($sformatf("io c%0d d_done", k), 32'(d_done), 32'(k == 4));
            if (k <= 3) chk($sformatf("io c%0d mem_a", k), mem_a, 32'h0003_0000);
            tick;
            if (k == 2) io_buffer_full = 1'b0;
        end
        chk("io writes", 32'(wr_count - w0), 32'h1);

        // Pause in cycle 1 of a fetch: data must still assemble correctly.
        if_req = 1'b1; if_addr = 32'h120;
        tick;
        if_req = 1'b0;
        tick;
        rdy_in = 1'b0;
        nif = 0; got = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            nif += int'(if_done);
            chk($sformatf("pause c%0d mem_wr", k), 32'(mem_wr), 32'h0);
            tick;
        end
        rdy_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (if_done) begin
                nif++;
                got = if_data;
            end
            tick;
        end
        chk("pause if_done count", 32'(nif), 32'h1);
        chk("pause if_data", got, 32'h4433_2211);

        // Async reset mid-access with the fetch slot occupied.
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h120;
        tick;
        if_req = 1'b0; d_req = 1'b0;
        tick;
        #2 rst_n_in = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(negedge clk_in);
        chk_reset_outputs("async held");
        @(posedge clk_in);
        #3 rst_n_in = 1'b1;
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            nd += int'(if_done) + int'(d_done) + int'(mem_wr);
            tick;
        end
        chk("post reset activity", 32'(nd), 32'h0);

        if_req = 1'b1; if_addr = 32'h100;
        tick;
        if_req = 1'b0;
        nif = 0; got = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_in);
            if (if_done) begin
                nif++;
                got = if_data;
            end
            tick;
        end
        chk("post reset fetch count", 32'(nif), 32'h1);
        chk("post reset fetch data", got, 32'h0000_0513);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
